// File: rtl/regfile_multiport.sv
// Multiport register file: NUM_RD combinational read ports, one write port,
// optional hardwired r0, and a one-entry-per-cycle clear sweep after rst or clear.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
//
// state    | meaning
// ST_CLEAR | sweeping idx_q over every entry writing zero; reads return 0
// ST_RUN   | normal operation; ready high, writes and reads enabled
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     regWrite,
  input  logic                     clear,
  output logic                     ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_to_zero;

  assign wr_to_zero = (ZERO_REG != 0) && (write_reg == '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    wr_en   = 1'b0;
    wr_addr = write_reg;
    wr_data = write_data;
    if (rst) begin
      // the array itself is never touched on a reset edge
      state_d = ST_CLEAR;
      idx_d   = '0;
      ready_d = 1'b0;
    end else if (clear) begin
      state_d = ST_CLEAR;
      idx_d   = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          wr_en   = 1'b1;
          wr_addr = idx_q;
          wr_data = '0;
          idx_d   = idx_q + 1'b1;
          if (idx_q == '1) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end
        end
        ST_RUN: begin
          wr_en = regWrite && !wr_to_zero;
        end
        default: begin
          state_d = ST_CLEAR;
          idx_d   = '0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign ready = ready_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_val;

    assign rd_addr = read_reg[p*ADDR_W +: ADDR_W];

    always_comb begin
      rd_val = '0;
      if (state_q == ST_RUN && !((ZERO_REG != 0) && (rd_addr == '0))) begin
        rd_val = regs_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
        if (regWrite && (write_reg == rd_addr)) begin
          rd_val = write_data;
        end
`endif
      end
    end

    assign read_data[p*DATA_W +: DATA_W] = rd_val;
  end

endmodule
